s1_tx: RTL

S1_TX -- requirements
Module: s1_tx

---
 rtl/s1_tx_if.sv | 33 +++
 rtl/s1_tx.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/s1_tx_if.sv
// Register-bank read port plus serial output lines of the S1 transmitter.
// The master side (s1_tx) drives the bank address/strobe and the serial
// lines. The slave side (register bank / receiver) supplies RB1_Q
// combinationally from RB1_A.
// Handshake: there is no valid/ready pair. RB1_Q is valid in the same cycle
// that RB1_A is presented. A serial bit is valid on every cycle where sen
// is low, and sen high marks idle, gap or done.
interface s1_tx_if;
  logic       RB1_RW;
  logic [4:0] RB1_A;
  logic [7:0] RB1_Q;
  logic       sen;
  logic       sd;
  logic       S1_done;

  modport master (
    output RB1_RW,
    output RB1_A,
    output sen,
    output sd,
    output S1_done,
    input  RB1_Q
  );

  modport slave (
    input  RB1_RW,
    input  RB1_A,
    input  sen,
    input  sd,
    input  S1_done,
    output RB1_Q
  );
endinterface

// File: rtl/s1_tx.sv
// S1 transmitter.
// The block reads 18 bytes from register bank RB1 into a buffer, then
// serialises 8 packets MSB first. Packet p carries the address p[2:0]
// followed by column p of the buffer, with word 0 first.
// Optional feature macro: S1_TX_PARITY_EN. It appends an even-parity bit
// (the XOR of the other 21 bits) as the last bit of every packet.
// Reset is asynchronous and active-low on rst.
module s1_tx (
  input  logic       clk,
  input  logic       rst,
  s1_tx_if.master    rb,
  output logic [1:0] dbg_state
);

`ifdef S1_TX_PARITY_EN
  localparam logic [4:0] LAST_IDX = 5'd21;
`else
  localparam logic [4:0] LAST_IDX = 5'd20;
`endif
  localparam logic [4:0] LAST_ADDR = 5'd17;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    SEND  = 2'd1,
    GAP   = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [4:0]  bit_q, bit_d;
  logic [2:0]  pkt_q, pkt_d;
  logic [4:0]  addr_q, addr_d;
  logic        sen_q, sen_d;
  logic        sd_q, sd_d;
  logic        done_q, done_d;
  logic [7:0]  buf_q [0:17];

  // Packet and bit about to be put on the wire at the next edge
  logic [2:0]        pkt_sel;
  logic [4:0]        bit_sel;
  logic [17:0]       col;
  logic [LAST_IDX:0] word;

  assign rb.RB1_RW   = 1'b1;
  assign rb.RB1_A    = addr_q;
  assign rb.sen      = sen_q;
  assign rb.sd       = sd_q;
  assign rb.S1_done  = done_q;
  assign dbg_state   = state_q;

  // Select which packet and bit the next registered sd value comes from
  always_comb begin
    pkt_sel = pkt_q;
    bit_sel = LAST_IDX;
    if (state_q == FETCH) begin
      pkt_sel = 3'd0;
    end else if (state_q == GAP) begin
      pkt_sel = pkt_q + 3'd1;
    end else if (state_q == SEND && bit_q != 5'd0) begin
      bit_sel = bit_q - 5'd1;
    end
  end

  // Assemble the selected packet: address bits on top, then column bits.
  // Word k lands at bit 17-k.
  always_comb begin
    col = '0;
    for (int k = 0; k < 18; k++) begin
      col[17-k] = buf_q[k][pkt_sel];
    end
`ifdef S1_TX_PARITY_EN
    word = {pkt_sel, col, ^{pkt_sel, col}};
`else
    word = {pkt_sel, col};
`endif
  end

  // Next-state and next-output logic
  always_comb begin
    state_d = state_q;
    bit_d   = bit_q;
    pkt_d   = pkt_q;
    addr_d  = 5'd0;
    sen_d   = 1'b1;
    sd_d    = 1'b0;
    done_d  = done_q;
    case (state_q)
      FETCH: begin
        if (addr_q == LAST_ADDR) begin
          state_d = SEND;
          bit_d   = LAST_IDX;
          pkt_d   = 3'd0;
          sen_d   = 1'b0;
          sd_d    = word[bit_sel];
        end else begin
          addr_d  = addr_q + 5'd1;
        end
      end
      SEND: begin
        if (bit_q != 5'd0) begin
          bit_d = bit_q - 5'd1;
          sen_d = 1'b0;
          sd_d  = word[bit_sel];
        end else if (pkt_q != 3'd7) begin
          state_d = GAP;
        end else begin
          state_d = DONE;
          done_d  = 1'b1;
        end
      end
      GAP: begin
        state_d = SEND;
        pkt_d   = pkt_q + 3'd1;
        bit_d   = LAST_IDX;
        sen_d   = 1'b0;
        sd_d    = word[bit_sel];
      end
      DONE: begin
        done_d = 1'b1;
      end
      default: begin
        state_d = FETCH;
      end
    endcase
  end

  // State, counters and registered outputs; reset aborts any transfer
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= FETCH;
      bit_q   <= 5'd0;
      pkt_q   <= 3'd0;
      addr_q  <= 5'd0;
      sen_q   <= 1'b1;
      sd_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      bit_q   <= bit_d;
      pkt_q   <= pkt_d;
      addr_q  <= addr_d;
      sen_q   <= sen_d;
      sd_q    <= sd_d;
      done_q  <= done_d;
    end
  end

  // Capture the bank word at the current address, only while fetching
  always_ff @(posedge clk) begin
    if (state_q == FETCH) begin
      buf_q[addr_q] <= rb.RB1_Q;
    end
  end

endmodule
